// File: rtl/instruction_bus_responder.sv
// Instruction-bus responder: single-outstanding word fetch with stale-data discard.
// Optional next-word prefetch buffer compiled in with IFETCH_PREFETCH_EN.
module instruction_bus_responder #(
  parameter logic [31:0] RESET_DATA = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instruction_request_i,
  input  logic        flush_bus_i,
  input  logic [31:0] instruction_addr_i,
  output logic        instruction_response_o,
  output logic [31:0] instruction_data_o,
  input  logic        buffer_invalidate_i,
  output logic        mem_read_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
);

`ifdef IFETCH_PREFETCH_EN
  typedef enum logic [2:0] {StIdle, StFetch, StRespond, StDrain, StPrefetch} state_e;
`else
  typedef enum logic [2:0] {StIdle, StFetch, StRespond, StDrain} state_e;
`endif

  state_e      state;
  logic [29:0] req_addr;
  logic [29:0] addr_word;
  logic        addr_match;
  logic        buf_hit;

  assign addr_word  = instruction_addr_i[31:2];
  assign addr_match = (addr_word == req_addr);

`ifdef IFETCH_PREFETCH_EN
  logic        buf_valid;
  logic [29:0] buf_addr;
  logic [31:0] buf_data;
  logic        pf_drop;
  logic        pf_keep;
  logic [29:0] next_word;
  logic        unused_bits;

  assign next_word   = req_addr + 30'd1;
  // A fence.i seen at any point while the prefetch is in flight poisons its data.
  assign pf_keep     = !pf_drop && !buffer_invalidate_i;
  assign buf_hit     = buf_valid && !buffer_invalidate_i && (buf_addr == addr_word);
  assign unused_bits = ^instruction_addr_i[1:0];
`else
  logic unused_bits;

  assign buf_hit     = 1'b0;
  assign unused_bits = ^{buffer_invalidate_i, instruction_addr_i[1:0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= StIdle;
      req_addr               <= '0;
      instruction_response_o <= 1'b0;
      instruction_data_o     <= RESET_DATA;
      mem_read_o             <= 1'b0;
      mem_addr_o             <= '0;
`ifdef IFETCH_PREFETCH_EN
      buf_valid              <= 1'b0;
      buf_addr               <= '0;
      buf_data               <= '0;
      pf_drop                <= 1'b0;
`endif
    end else begin
`ifdef IFETCH_PREFETCH_EN
      if (buffer_invalidate_i) buf_valid <= 1'b0;
`endif
      case (state)
        StIdle: begin
          if (instruction_request_i) begin
            req_addr <= addr_word;
            if (buf_hit) begin
`ifdef IFETCH_PREFETCH_EN
              instruction_data_o     <= buf_data;
`endif
              instruction_response_o <= 1'b1;
              state                  <= StRespond;
            end else begin
              mem_read_o <= 1'b1;
              mem_addr_o <= {addr_word, 2'b00};
              state      <= StFetch;
            end
          end
        end
        StFetch: begin
          if (mem_ack_i) begin
            mem_read_o <= 1'b0;
            // A redirect in the ack cycle, or an address that moved, makes the data stale.
            if (!flush_bus_i && addr_match) begin
              instruction_data_o     <= mem_data_i;
              instruction_response_o <= 1'b1;
              state                  <= StRespond;
            end else begin
              state <= StIdle;
            end
          end else if (flush_bus_i) begin
            state <= StDrain;
          end
        end
        StDrain: begin
          if (mem_ack_i) begin
            mem_read_o <= 1'b0;
            state      <= StIdle;
          end
        end
        StRespond: begin
          instruction_response_o <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
          req_addr   <= next_word;
          mem_read_o <= 1'b1;
          mem_addr_o <= {next_word, 2'b00};
          pf_drop    <= buffer_invalidate_i;
          state      <= StPrefetch;
`else
          state      <= StIdle;
`endif
        end
`ifdef IFETCH_PREFETCH_EN
        StPrefetch: begin
          if (buffer_invalidate_i) pf_drop <= 1'b1;
          if (mem_ack_i) begin
            mem_read_o <= 1'b0;
            if (pf_keep) begin
              buf_valid <= 1'b1;
              buf_addr  <= req_addr;
              buf_data  <= mem_data_i;
            end
            if (pf_keep && instruction_request_i && addr_match) begin
              instruction_data_o     <= mem_data_i;
              instruction_response_o <= 1'b1;
              state                  <= StRespond;
            end else begin
              state <= StIdle;
            end
          end else if (instruction_request_i && !addr_match) begin
            state <= StDrain;
          end
        end
`endif
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_bus_responder.sv
// Bench for instruction_bus_responder: directed scenarios plus randomized fetches
// checked against a static memory image; prefetch scenarios with IFETCH_PREFETCH_EN.
module tb_instruction_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instruction_request_i = 1'b0;
  logic        flush_bus_i = 1'b0;
  logic [31:0] instruction_addr_i = '0;
  logic        instruction_response_o;
  logic [31:0] instruction_data_o;
  logic        buffer_invalidate_i = 1'b0;
  logic        mem_read_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_data_i = '0;

  int n_checks = 0;
  int n_fail = 0;

  // Memory-side driver controls: manual values from the tasks or an auto responder.
  bit          auto_mem = 1'b0;
  logic        man_ack = 1'b0;
  logic [31:0] man_data = '0;
  int          lat = 0;

  instruction_bus_responder dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .instruction_request_i  (instruction_request_i),
    .flush_bus_i            (flush_bus_i),
    .instruction_addr_i     (instruction_addr_i),
    .instruction_response_o (instruction_response_o),
    .instruction_data_o     (instruction_data_o),
    .buffer_invalidate_i    (buffer_invalidate_i),
    .mem_read_o             (mem_read_o),
    .mem_addr_o             (mem_addr_o),
    .mem_ack_i              (mem_ack_i),
    .mem_data_i             (mem_data_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    mem_word = ({2'b00, w} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  always @(negedge clk) begin
    if (!auto_mem) begin
      mem_ack_i  = man_ack;
      mem_data_i = man_data;
    end else if (mem_ack_i) begin
      mem_ack_i = 1'b0;
      lat       = $urandom_range(0, 3);
    end else if (mem_read_o) begin
      if (lat == 0) begin
        mem_ack_i  = 1'b1;
        mem_data_i = mem_word(mem_addr_o[31:2]);
      end else begin
        lat--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Acks any outstanding read with image data so the buffer never holds junk.
  task automatic settle();
    instruction_request_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      man_ack  = mem_read_o && !man_ack;
      man_data = mem_word(mem_addr_o[31:2]);
    end
    man_ack = 1'b0;
    step();
  endtask

  task automatic test_reset();
    repeat (2) step();
    rst_n = 1'b1;
    instruction_addr_i    = 32'h40;
    instruction_request_i = 1'b1;
    step();
    n_checks++;
    if (mem_read_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_fetch: mem_read got %b expected 1", mem_read_o);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (instruction_response_o !== 1'b0 || instruction_data_o !== 32'h00000013 ||
        mem_read_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: got resp=%b data=%h rd=%b addr=%h expected 0/00000013/0/0",
               instruction_response_o, instruction_data_o, mem_read_o, mem_addr_o);
    end
    instruction_request_i = 1'b0;
    step();
    rst_n    = 1'b1;
    man_ack  = 1'b1;
    man_data = 32'h0BAD0BAD;
    step();
    man_ack = 1'b0;
    n_checks++;
    if (instruction_response_o !== 1'b0 || mem_read_o !== 1'b0 ||
        instruction_data_o !== 32'h00000013) begin
      n_fail++;
      $display("FAIL stray_ack: got resp=%b rd=%b data=%h expected 0/0/00000013",
               instruction_response_o, mem_read_o, instruction_data_o);
    end
    step();
    n_checks++;
    if (instruction_response_o !== 1'b0) begin
      n_fail++; $display("FAIL stray_ack_late: resp got %b expected 0", instruction_response_o);
    end
  endtask

  task automatic test_miss();
    instruction_addr_i    = 32'h100;
    instruction_request_i = 1'b1;
    step();
    n_checks++;
    if (mem_read_o !== 1'b1 || mem_addr_o !== 32'h100) begin
      n_fail++; $display("FAIL miss_issue: rd=%b addr=%h expected 1/00000100", mem_read_o, mem_addr_o);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (instruction_response_o !== 1'b0 || mem_read_o !== 1'b1 || mem_addr_o !== 32'h100) begin
        n_fail++;
        $display("FAIL miss_wait: resp=%b rd=%b addr=%h expected 0/1/00000100",
                 instruction_response_o, mem_read_o, mem_addr_o);
      end
    end
    man_ack  = 1'b1;
    man_data = 32'hDEADBEEF;
    step();
    man_ack = 1'b0;
    n_checks++;
    if (instruction_response_o !== 1'b1 || instruction_data_o !== 32'hDEADBEEF || mem_read_o !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_response: resp=%b data=%h rd=%b expected 1/deadbeef/0",
               instruction_response_o, instruction_data_o, mem_read_o);
    end
    instruction_request_i = 1'b0;
    step();
    n_checks++;
    if (instruction_response_o !== 1'b0) begin
      n_fail++; $display("FAIL miss_pulse: resp got %b expected 0", instruction_response_o);
    end
    settle();
  endtask

  task automatic test_unaligned();
    instruction_addr_i    = 32'h102;
    instruction_request_i = 1'b1;
    step();
    n_checks++;
    if (mem_read_o !== 1'b1 || mem_addr_o !== 32'h100) begin
      n_fail++; $display("FAIL unaligned_addr: rd=%b addr=%h expected 1/00000100", mem_read_o, mem_addr_o);
    end
    man_ack  = 1'b1;
    man_data = 32'hCAFEF00D;
    step();
    man_ack = 1'b0;
    n_checks++;
    if (instruction_response_o !== 1'b1 || instruction_data_o !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL unaligned_resp: resp=%b data=%h expected 1/cafef00d",
               instruction_response_o, instruction_data_o);
    end
    settle();
  endtask

  task automatic test_flush();
    instruction_addr_i    = 32'h100;
    instruction_request_i = 1'b1;
    step();
    step();
    flush_bus_i        = 1'b1;
    instruction_addr_i = 32'h200;
    step();
    flush_bus_i = 1'b0;
    n_checks++;
    if (instruction_response_o !== 1'b0 || mem_read_o !== 1'b1 || mem_addr_o !== 32'h100) begin
      n_fail++;
      $display("FAIL flush_drain: resp=%b rd=%b addr=%h expected 0/1/00000100",
               instruction_response_o, mem_read_o, mem_addr_o);
    end
    man_ack  = 1'b1;
    man_data = 32'h11110000;
    step();
    man_ack = 1'b0;
    n_checks++;
    if (instruction_response_o !== 1'b0 || mem_read_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_discard: resp=%b rd=%b expected 0/0", instruction_response_o, mem_read_o);
    end
    step();
    n_checks++;
    if (mem_read_o !== 1'b1 || mem_addr_o !== 32'h200) begin
      n_fail++; $display("FAIL flush_refetch: rd=%b addr=%h expected 1/00000200", mem_read_o, mem_addr_o);
    end
    man_ack  = 1'b1;
    man_data = 32'h22220000;
    step();
    man_ack = 1'b0;
    n_checks++;
    if (instruction_response_o !== 1'b1 || instruction_data_o !== 32'h22220000) begin
      n_fail++;
      $display("FAIL flush_resp: resp=%b data=%h expected 1/22220000",
               instruction_response_o, instruction_data_o);
    end
    settle();
  endtask

  task automatic test_flush_with_ack();
    instruction_addr_i    = 32'h180;
    instruction_request_i = 1'b1;
    step();
    flush_bus_i        = 1'b1;
    instruction_addr_i = 32'h1C0;
    man_ack            = 1'b1;
    man_data           = 32'h33330000;
    step();
    flush_bus_i = 1'b0;
    man_ack     = 1'b0;
    n_checks++;
    if (instruction_response_o !== 1'b0 || mem_read_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ack_discard: resp=%b rd=%b expected 0/0", instruction_response_o, mem_read_o);
    end
    step();
    n_checks++;
    if (mem_read_o !== 1'b1 || mem_addr_o !== 32'h1C0) begin
      n_fail++; $display("FAIL flush_ack_refetch: rd=%b addr=%h expected 1/000001c0", mem_read_o, mem_addr_o);
    end
    man_ack  = 1'b1;
    man_data = 32'h44440000;
    step();
    man_ack = 1'b0;
    n_checks++;
    if (instruction_response_o !== 1'b1 || instruction_data_o !== 32'h44440000) begin
      n_fail++;
      $display("FAIL flush_ack_resp: resp=%b data=%h expected 1/44440000",
               instruction_response_o, instruction_data_o);
    end
    settle();
  endtask

  // Whatever path the DUT takes, every response must carry the image word at the current address.
  task automatic test_random();
    logic [31:0] a;
    logic [31:0] na;
    logic [29:0] exp_w;
    logic        prev_read;
    logic [31:0] prev_addr;
    int          flush_at;
    bit          got;
    auto_mem            = 1'b1;
    buffer_invalidate_i = 1'b1;
    step();
    buffer_invalidate_i = 1'b0;
    a = 32'h400;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = {a[31:2] + 30'd1, 2'($urandom_range(0, 3))};
        2:       a = $urandom & 32'h00000FFF;
        default: a = {30'h3FFFFFFF - 30'($urandom_range(0, 1)), 2'b00};
      endcase
      exp_w                 = a[31:2];
      instruction_addr_i    = a;
      instruction_request_i = 1'b1;
      flush_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      got       = 1'b0;
      prev_read = mem_read_o;
      prev_addr = mem_addr_o;
      for (int c = 0; c < 60 && !got; c++) begin
        if (c == flush_at) begin
          na                 = $urandom & 32'h0000FFFC;
          flush_bus_i        = 1'b1;
          instruction_addr_i = na;
          exp_w              = na[31:2];
        end
        step();
        flush_bus_i = 1'b0;
        if (prev_read && mem_read_o) begin
          n_checks++;
          if (mem_addr_o !== prev_addr) begin
            n_fail++; $display("FAIL mem_addr_stable: got %h expected %h", mem_addr_o, prev_addr);
          end
        end
        prev_read = mem_read_o;
        prev_addr = mem_addr_o;
        got       = instruction_response_o;
      end
      n_checks++;
      if (!got) begin
        n_fail++; $display("FAIL rand_timeout: no response for word %h", exp_w);
      end else if (instruction_data_o !== mem_word(exp_w)) begin
        n_fail++;
        $display("FAIL rand_data: word %h got %h expected %h", exp_w, instruction_data_o, mem_word(exp_w));
      end
      instruction_request_i = 1'b0;
      step();
      n_checks++;
      if (instruction_response_o !== 1'b0) begin
        n_fail++; $display("FAIL rand_pulse: resp got %b expected 0", instruction_response_o);
      end
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

`ifdef IFETCH_PREFETCH_EN
  task automatic wait_resp(input logic [29:0] w, input string name);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      step();
      got = instruction_response_o;
    end
    n_checks++;
    if (!got || instruction_data_o !== mem_word(w)) begin
      n_fail++;
      $display("FAIL %s: resp=%b data=%h expected 1/%h", name, got, instruction_data_o, mem_word(w));
    end
  endtask

  task automatic wait_idle(input string name);
    instruction_request_i = 1'b0;
    step();
    for (int c = 0; c < 20 && mem_read_o; c++) step();
    n_checks++;
    if (mem_read_o !== 1'b0) begin
      n_fail++; $display("FAIL %s: mem_read got %b expected 0", name, mem_read_o);
    end
  endtask

  task automatic test_prefetch_hit();
    instruction_request_i = 1'b0;
    repeat (8) step();
    instruction_addr_i    = 32'h300;
    instruction_request_i = 1'b1;
    wait_resp(30'h0C0, "pf_first");
    wait_idle("pf_fill");
    instruction_addr_i    = 32'h304;
    instruction_request_i = 1'b1;
    step();
    n_checks++;
    if (instruction_response_o !== 1'b1 || mem_read_o !== 1'b0 || instruction_data_o !== mem_word(30'h0C1)) begin
      n_fail++;
      $display("FAIL pf_hit: resp=%b rd=%b data=%h expected 1/0/%h",
               instruction_response_o, mem_read_o, instruction_data_o, mem_word(30'h0C1));
    end
    instruction_request_i = 1'b0;
    step();
    n_checks++;
    if (instruction_response_o !== 1'b0) begin
      n_fail++; $display("FAIL pf_hit_pulse: resp got %b expected 0", instruction_response_o);
    end
  endtask

  task automatic test_invalidate();
    wait_idle("inv_fill");
    buffer_invalidate_i = 1'b1;
    step();
    buffer_invalidate_i   = 1'b0;
    instruction_addr_i    = 32'h308;
    instruction_request_i = 1'b1;
    step();
    n_checks++;
    if (instruction_response_o !== 1'b0 || mem_read_o !== 1'b1 || mem_addr_o !== 32'h308) begin
      n_fail++;
      $display("FAIL inv_miss: resp=%b rd=%b addr=%h expected 0/1/00000308",
               instruction_response_o, mem_read_o, mem_addr_o);
    end
    wait_resp(30'h0C2, "inv_resp");
    instruction_request_i = 1'b0;
    buffer_invalidate_i   = 1'b1;
    step();
    buffer_invalidate_i = 1'b0;
    wait_idle("inv_pf_done");
    instruction_addr_i    = 32'h30C;
    instruction_request_i = 1'b1;
    step();
    n_checks++;
    if (instruction_response_o !== 1'b0 || mem_read_o !== 1'b1 || mem_addr_o !== 32'h30C) begin
      n_fail++;
      $display("FAIL inv_pf_drop: resp=%b rd=%b addr=%h expected 0/1/0000030c",
               instruction_response_o, mem_read_o, mem_addr_o);
    end
    wait_resp(30'h0C3, "inv_pf_resp");
    instruction_request_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_miss();
    test_unaligned();
    test_flush();
    test_flush_with_ack();
    test_random();
`ifdef IFETCH_PREFETCH_EN
    test_prefetch_hit();
    test_invalidate();
`endif
    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
